// File: rtl/eq_band_mixer.sv
// eq_band_mixer: combines NB signed 24-bit band samples, each scaled by its
// own signed Q2.14 gain, into one equalized 24-bit output sample.
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_en       sample strobe; captures i_data/i_gain when idle
//   i_data     NB packed signed 24-bit band samples, band b at [24b+23:24b]
//   i_gain     NB packed signed Q2.14 gains, band b at [GW*b+GW-1:GW*b]
//   o_data     signed mixed output sample, held between valid pulses
//   o_valid    one-cycle pulse when o_data updates
//   o_clip     high with o_valid when the output saturated
//   o_busy     high while a mix is in progress (MAC and OUT)
//   o_overrun  sticky; a strobe arrived while busy and was dropped
//
// The result is rounded, saturated and registered on the last MAC cycle,
// so the valid pulse coincides with the OUT state. This keeps latency at
// NB+1 clocks and lets the next strobe be taken right after the pulse.
module eq_band_mixer #(
    parameter int NB = 8,
    parameter int GW = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [NB*24-1:0] i_data,
    input  logic [NB*GW-1:0] i_gain,
    output logic [23:0]      o_data,
    output logic             o_valid,
    output logic             o_clip,
    output logic             o_busy,
    output logic             o_overrun
);

    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = 24 + GW;
    localparam int AW = PW + $clog2(NB);

    localparam logic signed [AW-1:0] RND  = AW'(8192);
    localparam logic signed [AW-1:0] SMAX = AW'(8388607);
    localparam logic signed [AW-1:0] SMIN = AW'(-8388608);
    localparam logic [IW-1:0]        LAST = IW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state;

    logic [NB*24-1:0]       snap_data;
    logic [NB*GW-1:0]       snap_gain;
    logic signed [AW-1:0]   acc;
    logic [IW-1:0]          idx;

    logic signed [23:0]     cur_d;
    logic signed [GW-1:0]   cur_g;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   rsum;
    logic signed [AW-1:0]   shifted;
    logic [23:0]            sat_data;
    logic                   sat_clip;

    assign cur_d = snap_data[32'(idx)*24 +: 24];
    assign cur_g = snap_gain[32'(idx)*GW +: GW];

    // Both operands sign-extended to the full product width.
    assign prod = $signed({{GW{cur_d[23]}}, cur_d})
                * $signed({{24{cur_g[GW-1]}}, cur_g});

    assign acc_next = acc + $signed({{(AW-PW){prod[PW-1]}}, prod});

    // Round half toward +inf, then drop the Q2.14 fraction.
    assign rsum    = acc_next + RND;
    assign shifted = rsum >>> 14;

    always_comb begin
        sat_data = shifted[23:0];
        sat_clip = 1'b0;
        if (shifted > SMAX) begin
            sat_data = 24'h7FFFFF;
            sat_clip = 1'b1;
        end else if (shifted < SMIN) begin
            sat_data = 24'h800000;
            sat_clip = 1'b1;
        end
    end

    assign o_busy = (state != IDLE);

    // Snapshot banks carry no reset; they are only read after a capture.
    always_ff @(posedge i_clk) begin
        if (!i_rst && state == IDLE && i_en) begin
            snap_data <= i_data;
            snap_gain <= i_gain;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_clip    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_clip  <= 1'b0;
            if (i_en && state != IDLE) begin
                o_overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (i_en) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    idx <= idx + IW'(1);
                    if (idx == LAST) begin
                        o_data  <= sat_data;
                        o_clip  <= sat_clip;
                        o_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb_eq_band_mixer: directed vectors and corner sequences for eq_band_mixer
// built with four bands and Q2.14 gains.
module tb_eq_band_mixer;

    localparam int NB = 4;
    localparam int GW = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic [NB-1:0][23:0] data;
    logic [NB-1:0][GW-1:0] gain;
    logic [23:0]      o_data;
    logic             o_valid;
    logic             o_clip;
    logic             o_busy;
    logic             o_overrun;

    int n_cmp = 0;
    int n_err = 0;

    eq_band_mixer #(.NB(NB), .GW(GW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_data    (data),
        .i_gain    (gain),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_clip    (o_clip),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string               nm;
        logic [NB-1:0][23:0] d;
        logic [NB-1:0][GW-1:0] g;
        logic [23:0]         ed;
        logic                ec;
    } vec_t;

    vec_t vecs[10];

    // Each cycle begins just after a rising edge: outputs are checked
    // there, then inputs for that cycle are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        en   = 1'b1;
        data = v.d;
        gain = v.g;
        for (int c = 1; c <= 7; c++) begin
            tick();
            en   = 1'b0;
            data = {NB{24'h5A5A5A}};
            gain = {NB{16'h1234}};
            chk({v.nm, "_valid"}, 32'(o_valid), 32'(c == 5));
            chk({v.nm, "_busy"}, 32'(o_busy), 32'(c >= 1 && c <= 5));
            if (c == 5) begin
                chk({v.nm, "_data"}, 32'(o_data), 32'(v.ed));
                chk({v.nm, "_clip"}, 32'(o_clip), 32'(v.ec));
            end else begin
                chk({v.nm, "_clip0"}, 32'(o_clip), 32'd0);
            end
            if (c == 7) begin
                chk({v.nm, "_hold"}, 32'(o_data), 32'(v.ed));
            end
        end
    endtask

    initial begin
        vecs[0].nm = "single";
        vecs[0].d  = {24'd5555, 24'd5555, 24'd5555, 24'd1000};
        vecs[0].g  = {16'h0, 16'h0, 16'h0, 16'h4000};
        vecs[0].ed = 24'd1000;
        vecs[0].ec = 1'b0;
        vecs[1].nm = "pos_sat";
        vecs[1].d  = {NB{24'h300000}};
        vecs[1].g  = {NB{16'h4000}};
        vecs[1].ed = 24'h7FFFFF;
        vecs[1].ec = 1'b1;
        vecs[2].nm = "neg_sat";
        vecs[2].d  = {NB{24'h800000}};
        vecs[2].g  = {NB{16'h7FFF}};
        vecs[2].ed = 24'h800000;
        vecs[2].ec = 1'b1;
        vecs[3].nm = "round_pos";
        vecs[3].d  = {24'd0, 24'd0, 24'd0, 24'd3};
        vecs[3].g  = {16'h0, 16'h0, 16'h0, 16'h2000};
        vecs[3].ed = 24'd2;
        vecs[3].ec = 1'b0;
        vecs[4].nm = "round_neg";
        vecs[4].d  = {24'd0, 24'd0, 24'd0, 24'hFFFFFD};
        vecs[4].g  = {16'h0, 16'h0, 16'h0, 16'h2000};
        vecs[4].ed = 24'hFFFFFF;
        vecs[4].ec = 1'b0;
        vecs[5].nm = "mix";
        vecs[5].d  = {24'd400, 24'hFFFED4, 24'd200, 24'd100};
        vecs[5].g  = {16'h1000, 16'hC000, 16'h2000, 16'h4000};
        vecs[5].ed = 24'd600;
        vecs[5].ec = 1'b0;
        vecs[6].nm = "max_exact";
        vecs[6].d  = {24'd0, 24'd0, 24'd0, 24'h7FFFFF};
        vecs[6].g  = {16'h0, 16'h0, 16'h0, 16'h4000};
        vecs[6].ed = 24'h7FFFFF;
        vecs[6].ec = 1'b0;
        vecs[7].nm = "max_over";
        vecs[7].d  = {24'd0, 24'd0, 24'd0, 24'h7FFFFF};
        vecs[7].g  = {16'h0, 16'h0, 16'h0, 16'h4001};
        vecs[7].ed = 24'h7FFFFF;
        vecs[7].ec = 1'b1;
        vecs[8].nm = "min_exact";
        vecs[8].d  = {24'd0, 24'd0, 24'd0, 24'h800000};
        vecs[8].g  = {16'h0, 16'h0, 16'h0, 16'h4000};
        vecs[8].ed = 24'h800000;
        vecs[8].ec = 1'b0;
        vecs[9].nm = "half_neg";
        vecs[9].d  = {24'd0, 24'd0, 24'd0, 24'hFFFFFF};
        vecs[9].g  = {16'h0, 16'h0, 16'h0, 16'h2000};
        vecs[9].ed = 24'd0;
        vecs[9].ec = 1'b0;

        rst  = 1'b1;
        en   = 1'b0;
        data = '0;
        gain = '0;
        tick();
        tick();
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_clip", 32'(o_clip), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ovr", 32'(o_overrun), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end
        chk("no_ovr_yet", 32'(o_overrun), 32'd0);

        // Overrun, snapshot isolation, OUT-cycle drop, earliest restart.
        en   = 1'b1;
        data = {24'd5555, 24'd5555, 24'd5555, 24'd1000};
        gain = {16'h0, 16'h0, 16'h0, 16'h4000};
        for (int c = 1; c <= 12; c++) begin
            tick();
            en   = (c == 2) || (c == 5) || (c == 6);
            data = {NB{24'd7}};
            gain = {NB{16'h4000}};
            if (c <= 2) begin
                chk("ovr_early", 32'(o_overrun), 32'd0);
            end else begin
                chk("ovr_sticky", 32'(o_overrun), 32'd1);
            end
            chk("ovr_valid", 32'(o_valid), 32'(c == 5 || c == 11));
            if (c == 5) begin
                chk("ovr_data", 32'(o_data), 32'd1000);
            end
            if (c == 6) begin
                chk("idle_after_out", 32'(o_busy), 32'd0);
            end
            if (c == 11) begin
                chk("restart_data", 32'(o_data), 32'd28);
            end
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovr_clear", 32'(o_overrun), 32'd0);
        chk("ovr_clr_data", 32'(o_data), 32'd0);

        // Put a nonzero value on o_data, then reset mid-mix.
        run_vec(vecs[0]);
        en   = 1'b1;
        data = {24'd5555, 24'd5555, 24'd5555, 24'd77};
        gain = {16'h0, 16'h0, 16'h0, 16'h4000};
        for (int c = 1; c <= 11; c++) begin
            tick();
            en   = (c == 4);
            rst  = (c == 2);
            data = vecs[5].d;
            gain = vecs[5].g;
            chk("mid_valid", 32'(o_valid), 32'(c == 9));
            if (c == 3) begin
                chk("mid_data0", 32'(o_data), 32'd0);
                chk("mid_busy0", 32'(o_busy), 32'd0);
                chk("mid_clip0", 32'(o_clip), 32'd0);
            end
            if (c == 9) begin
                chk("mid_data", 32'(o_data), 32'd600);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
